// File: rtl/gcbp_pkg.sv
// Shared GCBP definitions: array geometry, frame-slot encoding and the BRAM address format.
package gcbp_pkg;

   localparam int C_SUBIMAGE_HEIGHT = 64;
   localparam int C_NUM_SUBIMAGES   = 16;
   localparam int C_LINE_BITS       = 128;
   localparam int C_ADDR_BITS       = 9;

   localparam int C_LINE_IDX_BITS = $clog2(C_SUBIMAGE_HEIGHT);
   localparam int C_SUB_IDX_BITS  = $clog2(C_NUM_SUBIMAGES);
   localparam int C_TAG_BITS      = C_SUB_IDX_BITS + C_LINE_IDX_BITS;

   // Three frame slots live in each BRAM; encoding 3 never holds a frame.
   typedef enum logic [1:0] {
      LOC_SLOT0   = 2'd0,
      LOC_SLOT1   = 2'd1,
      LOC_SLOT2   = 2'd2,
      LOC_INVALID = 2'd3
   } frame_loc_e;

   function automatic logic [C_ADDR_BITS-1:0] gcbp_addr(input logic [1:0] loc,
                                                        input logic [C_LINE_IDX_BITS-1:0] line);
      return C_ADDR_BITS'({loc, line});
   endfunction

   function automatic logic loc_pair_ok(input logic [1:0] curr, input logic [1:0] prev);
      return (curr != LOC_INVALID) && (prev != LOC_INVALID) && (curr != prev);
   endfunction

endpackage

// File: rtl/gcbp_skid_fifo.sv
// Fall-through skid FIFO: a push into an empty FIFO is visible on pop_dat the same cycle.
// Zero-cycle latency when empty; caller must not push when count == DEPTH (credit guarded upstream).
module gcbp_skid_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 266,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic             vld,
   output logic [CW-1:0]    count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             empty, bypass, wr, rd;

   assign empty   = (count == '0);
   assign bypass  = empty & push & pop;
   assign wr      = push & ~bypass;
   assign rd      = pop & ~empty;
   assign vld     = ~empty | push;
   assign pop_dat = empty ? push_dat : mem[rd_ptr];

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         end
         if (rd) begin
            rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         end
         count <= count + CW'(wr) - CW'(rd);
      end
   end

endmodule

// File: rtl/gcbp_bram_reader.sv
// Streams curr/prev frame lines of all 16 sub-images from the GCBP array; first beat C_RD_LATENCY+1 cycles after start.
// Credit-limited reads so a stalled consumer never loses BRAM data; one beat per cycle when unstalled.
module gcbp_bram_reader
   import gcbp_pkg::*;
#(
   parameter int C_RD_LATENCY = 1
) (
   input  logic                       i_clk,
   input  logic                       i_resetn,
   input  logic                       i_start,
   input  logic [1:0]                 i_curr_frame_loc,
   input  logic [1:0]                 i_prev_frame_loc,
   output logic [C_SUB_IDX_BITS-1:0]  o_bram_array_read_sel,
   output logic [C_ADDR_BITS-1:0]     o_bram_array_read_addr_a,
   output logic [C_ADDR_BITS-1:0]     o_bram_array_read_addr_b,
   output logic                       o_bram_array_read_en,
   input  logic [C_LINE_BITS-1:0]     i_bram_array_read_data_a,
   input  logic [C_LINE_BITS-1:0]     i_bram_array_read_data_b,
   output logic [C_LINE_BITS-1:0]     o_curr_line,
   output logic [C_LINE_BITS-1:0]     o_prev_line,
   output logic                       o_line_valid,
   input  logic                       i_line_ready,
   output logic [C_SUB_IDX_BITS-1:0]  o_subimage_idx,
   output logic [C_LINE_IDX_BITS-1:0] o_line_idx,
   output logic                       o_subimage_last,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_err
);
   localparam int C_FIFO_DEPTH = C_RD_LATENCY + 1;
   localparam int C_CNT_BITS   = $clog2(C_FIFO_DEPTH + 1);
   localparam int C_FIFO_W     = 2 * C_LINE_BITS + C_TAG_BITS;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

   state_e                     state;
   logic [1:0]                 curr_loc_q, prev_loc_q;
   logic [C_SUB_IDX_BITS-1:0]  sub_cnt;
   logic [C_LINE_IDX_BITS-1:0] line_cnt;
   logic                       done_q, err_q;
   logic [C_RD_LATENCY-1:0]    cap_vld;
   logic [C_TAG_BITS-1:0]      cap_tag [C_RD_LATENCY];
   logic [C_CNT_BITS-1:0]      in_flight, fifo_cnt;
   logic                       credit_ok, rd_en, fifo_vld;
   logic [C_FIFO_W-1:0]        fifo_dat;
   logic [C_TAG_BITS-1:0]      beat_tag;

   always_comb begin
      in_flight = '0;
      for (int i = 0; i < C_RD_LATENCY; i++) begin
         in_flight = in_flight + C_CNT_BITS'(cap_vld[i]);
      end
   end

   // Every read in flight already owns a FIFO slot, so the FIFO can never overflow.
   assign credit_ok = ({1'b0, in_flight} + {1'b0, fifo_cnt}) < (C_CNT_BITS + 1)'(C_FIFO_DEPTH);
   assign rd_en     = i_resetn && (state == S_READ) && credit_ok;

   assign o_bram_array_read_en     = rd_en;
   assign o_bram_array_read_sel    = rd_en ? sub_cnt : '0;
   assign o_bram_array_read_addr_a = rd_en ? gcbp_addr(curr_loc_q, line_cnt) : '0;
   assign o_bram_array_read_addr_b = rd_en ? gcbp_addr(prev_loc_q, line_cnt) : '0;

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         state      <= S_IDLE;
         curr_loc_q <= '0;
         prev_loc_q <= '0;
         sub_cnt    <= '0;
         line_cnt   <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  if (loc_pair_ok(i_curr_frame_loc, i_prev_frame_loc)) begin
                     curr_loc_q <= i_curr_frame_loc;
                     prev_loc_q <= i_prev_frame_loc;
                     sub_cnt    <= '0;
                     line_cnt   <= '0;
                     state      <= S_READ;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_READ: begin
               if (rd_en) begin
                  line_cnt <= line_cnt + C_LINE_IDX_BITS'(1);
                  if (line_cnt == C_LINE_IDX_BITS'(C_SUBIMAGE_HEIGHT - 1)) begin
                     sub_cnt <= sub_cnt + C_SUB_IDX_BITS'(1);
                     if (sub_cnt == C_SUB_IDX_BITS'(C_NUM_SUBIMAGES - 1)) begin
                        state <= S_DRAIN;
                     end
                  end
               end
            end
            S_DRAIN: begin
               if (in_flight == '0 && fifo_cnt == '0) begin
                  state  <= S_DONE;
                  done_q <= 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Valid/tag shift register mirrors the BRAM pipeline so data and tags land together.
   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         cap_vld <= '0;
      end else begin
         cap_vld[0] <= rd_en;
         for (int i = 1; i < C_RD_LATENCY; i++) begin
            cap_vld[i] <= cap_vld[i-1];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      cap_tag[0] <= {sub_cnt, line_cnt};
      for (int i = 1; i < C_RD_LATENCY; i++) begin
         cap_tag[i] <= cap_tag[i-1];
      end
   end

   gcbp_skid_fifo #(
      .DEPTH (C_FIFO_DEPTH),
      .WIDTH (C_FIFO_W),
      .CW    (C_CNT_BITS)
   ) u_skid_fifo (
      .i_clk    (i_clk),
      .i_resetn (i_resetn),
      .push     (cap_vld[C_RD_LATENCY-1]),
      .push_dat ({i_bram_array_read_data_a, i_bram_array_read_data_b, cap_tag[C_RD_LATENCY-1]}),
      .pop      (o_line_valid & i_line_ready),
      .pop_dat  (fifo_dat),
      .vld      (fifo_vld),
      .count    (fifo_cnt)
   );

   assign o_line_valid    = i_resetn & fifo_vld;
   assign beat_tag        = o_line_valid ? fifo_dat[C_TAG_BITS-1:0] : '0;
   assign o_curr_line     = o_line_valid ? fifo_dat[C_FIFO_W-1 -: C_LINE_BITS] : '0;
   assign o_prev_line     = o_line_valid ? fifo_dat[C_TAG_BITS +: C_LINE_BITS] : '0;
   assign o_subimage_idx  = beat_tag[C_TAG_BITS-1 -: C_SUB_IDX_BITS];
   assign o_line_idx      = beat_tag[C_LINE_IDX_BITS-1:0];
   assign o_subimage_last = o_line_valid && (o_line_idx == C_LINE_IDX_BITS'(C_SUBIMAGE_HEIGHT - 1));

   assign o_busy = i_resetn && (state != S_IDLE);
   assign o_done = i_resetn & done_q;
   assign o_err  = i_resetn & err_q;

endmodule

// File: tb/tb_gcbp_bram_reader.sv
// Runs a latency-1 and a latency-2 reader side by side on identical stimulus against a frame-order model.
module tb_gcbp_bram_reader;
   localparam int NB = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstn, start, ready;
   logic [1:0] loc_c, loc_p;

   logic [3:0]   sel [2];
   logic [8:0]   addr_a [2], addr_b [2];
   logic         rd_en [2], vld [2], last [2], busy [2], done [2], err [2];
   logic [127:0] curr [2], prev [2];
   logic [3:0]   sub [2];
   logic [5:0]   lidx [2];

   int n_vec = 0, n_err = 0, cyc = 0;
   bit stim_done = 1'b0, rst_prev = 1'b0;

   bit         active [2], err_exp [2], stall_prev [2];
   logic [1:0] m_c [2], m_p [2];
   int         rd_idx [2], bt_idx [2], outstanding [2], last_xfer [2], start_cyc [2];
   int         done_cnt [2], err_cnt [2], done_cyc [2], first_beat_cyc [2];
   logic [8:0]   first_a [2], first_b [2];
   logic [127:0] first_curr [2], first_prev [2];
   logic [9:0]   first_tag [2];

   function automatic logic [127:0] word(input logic [1:0] slot, input logic [3:0] bram,
                                         input logic [5:0] line);
      return {116'd0, slot, bram, line};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [127:0] s0a, s0b, s1a, s1b;
      always @(posedge clk) begin
         if (rd_en[g]) begin
            s0a <= word(addr_a[g][7:6], sel[g], addr_a[g][5:0]);
            s0b <= word(addr_b[g][7:6], sel[g], addr_b[g][5:0]);
         end
         s1a <= s0a;
         s1b <= s0b;
      end
      gcbp_bram_reader #(.C_RD_LATENCY(g + 1)) u_dut (
         .i_clk                    (clk),
         .i_resetn                 (rstn),
         .i_start                  (start),
         .i_curr_frame_loc         (loc_c),
         .i_prev_frame_loc         (loc_p),
         .o_bram_array_read_sel    (sel[g]),
         .o_bram_array_read_addr_a (addr_a[g]),
         .o_bram_array_read_addr_b (addr_b[g]),
         .o_bram_array_read_en     (rd_en[g]),
         .i_bram_array_read_data_a (g == 0 ? s0a : s1a),
         .i_bram_array_read_data_b (g == 0 ? s0b : s1b),
         .o_curr_line              (curr[g]),
         .o_prev_line              (prev[g]),
         .o_line_valid             (vld[g]),
         .i_line_ready             (ready),
         .o_subimage_idx           (sub[g]),
         .o_line_idx               (lidx[g]),
         .o_subimage_last          (last[g]),
         .o_busy                   (busy[g]),
         .o_done                   (done[g]),
         .o_err                    (err[g])
      );
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic monitor_cycle();
      cyc++;
      for (int g = 0; g < 2; g++) begin
         int    lat;
         int    s, l;
         string u;
         lat = g + 1;
         u   = $sformatf("u%0d", g);
         if (!rstn) begin
            if (rst_prev)
               chk({u, ".reset_outputs"}, 128'({|curr[g], |prev[g], sel[g], addr_a[g], addr_b[g], rd_en[g],
                   vld[g], sub[g], lidx[g], last[g], busy[g], done[g], err[g]}), 128'(0));
            active[g] = 0; err_exp[g] = 0; stall_prev[g] = 0; outstanding[g] = 0;
            rd_idx[g] = 0; bt_idx[g] = 0; last_xfer[g] = -10;
         end else begin
            chk({u, ".busy"}, 128'(busy[g]), 128'(active[g]));
            chk({u, ".err"}, 128'(err[g]), 128'(err_exp[g]));
            err_exp[g] = 0;
            chk({u, ".done"}, 128'(done[g]), 128'(active[g] && cyc == last_xfer[g] + 2));
            if (done[g]) begin done_cnt[g]++; done_cyc[g] = cyc; end
            if (err[g]) err_cnt[g]++;
            if (!active[g] || rd_idx[g] >= NB || outstanding[g] >= lat + 1) begin
               chk({u, ".rd_en_blocked"}, 128'(rd_en[g]), 128'(0));
            end else if (rd_en[g]) begin
               s = rd_idx[g] / 64;
               l = rd_idx[g] % 64;
               chk({u, ".rd_sel"}, 128'(sel[g]), 128'(s));
               chk({u, ".rd_addr_a"}, 128'(addr_a[g]), 128'(m_c[g] * 64 + l));
               chk({u, ".rd_addr_b"}, 128'(addr_b[g]), 128'(m_p[g] * 64 + l));
               if (rd_idx[g] == 0) begin first_a[g] = addr_a[g]; first_b[g] = addr_b[g]; end
               rd_idx[g]++;
            end
            if (vld[g]) begin
               if (!active[g] || bt_idx[g] >= NB) begin
                  chk({u, ".spurious_beat"}, 128'(vld[g]), 128'(0));
               end else begin
                  s = bt_idx[g] / 64;
                  l = bt_idx[g] % 64;
                  chk({u, ".beat_sub"}, 128'(sub[g]), 128'(s));
                  chk({u, ".beat_line"}, 128'(lidx[g]), 128'(l));
                  chk({u, ".beat_last"}, 128'(last[g]), 128'(l == 63));
                  chk({u, ".beat_curr"}, curr[g], word(m_c[g], 4'(s), 6'(l)));
                  chk({u, ".beat_prev"}, prev[g], word(m_p[g], 4'(s), 6'(l)));
                  if (bt_idx[g] == 0) begin
                     first_beat_cyc[g] = cyc;
                     first_curr[g] = curr[g];
                     first_prev[g] = prev[g];
                     first_tag[g] = {sub[g], lidx[g]};
                  end
                  if (ready) begin
                     bt_idx[g]++;
                     if (bt_idx[g] == NB) last_xfer[g] = cyc;
                  end
               end
            end else if (stall_prev[g]) begin
               chk({u, ".valid_dropped_while_stalled"}, 128'(vld[g]), 128'(1));
            end
            stall_prev[g] = vld[g] && !ready;
            outstanding[g] += int'(rd_en[g]) - int'(vld[g] && ready);
            if (start && !active[g]) begin
               if (loc_c == 2'd3 || loc_p == 2'd3 || loc_c == loc_p) begin
                  err_exp[g] = 1;
               end else begin
                  active[g] = 1; m_c[g] = loc_c; m_p[g] = loc_p;
                  rd_idx[g] = 0; bt_idx[g] = 0; last_xfer[g] = -10; start_cyc[g] = cyc;
               end
            end
            if (done[g]) active[g] = 0;
         end
      end
      rst_prev = !rstn;
   endtask

   task automatic tick(input bit rnd);
      @(posedge clk);
      #1;
      ready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
   endtask

   task automatic pulse_start(input logic [1:0] c, input logic [1:0] p);
      start = 1'b1; loc_c = c; loc_p = p;
      tick(0);
      start = 1'b0;
   endtask

   task automatic run_until_done(input int budget, input bit rnd, input int b0, input int b1);
      int n;
      n = 0;
      while (!(done_cnt[0] > b0 && done_cnt[1] > b1) && n < budget) begin
         tick(rnd);
         n++;
      end
      tick(0);
      chk("u0.pass_done_count", 128'(done_cnt[0]), 128'(b0 + 1));
      chk("u1.pass_done_count", 128'(done_cnt[1]), 128'(b1 + 1));
   endtask

   initial begin
      rstn = 1'b0; start = 1'b0; ready = 1'b1; loc_c = 2'd0; loc_p = 2'd0;
      for (int g = 0; g < 2; g++) begin
         done_cnt[g] = 0; err_cnt[g] = 0; last_xfer[g] = -10;
      end
      fork
         while (!stim_done) begin
            @(negedge clk);
            monitor_cycle();
         end
         begin
            int d0, d1, n;
            repeat (4) tick(0);
            rstn = 1'b1;
            repeat (2) tick(0);

            // full-rate pass, curr=1 prev=0, with an ignored start mid-pass
            pulse_start(2'd1, 2'd0);
            repeat (200) tick(0);
            pulse_start(2'd2, 2'd1);
            run_until_done(3000, 0, 0, 0);
            for (int g = 0; g < 2; g++) begin
               chk($sformatf("u%0d.first_addr_a", g), 128'(first_a[g]), 128'(64));
               chk($sformatf("u%0d.first_addr_b", g), 128'(first_b[g]), 128'(0));
               chk($sformatf("u%0d.first_curr", g), first_curr[g], 128'h400);
               chk($sformatf("u%0d.first_prev", g), first_prev[g], 128'h0);
               chk($sformatf("u%0d.first_tag", g), 128'(first_tag[g]), 128'(0));
               chk($sformatf("u%0d.first_beat_latency", g), 128'(first_beat_cyc[g] - start_cyc[g]), 128'(g + 2));
               chk($sformatf("u%0d.full_rate_span", g), 128'(last_xfer[g] - first_beat_cyc[g]), 128'(1023));
               chk($sformatf("u%0d.done_after_last", g), 128'(done_cyc[g] - last_xfer[g]), 128'(2));
            end

            // rejected starts
            repeat (3) tick(0);
            pulse_start(2'd2, 2'd2);
            repeat (3) tick(0);
            pulse_start(2'd3, 2'd0);
            repeat (3) tick(0);
            chk("u0.err_pulses", 128'(err_cnt[0]), 128'(2));
            chk("u1.err_pulses", 128'(err_cnt[1]), 128'(2));

            // backpressured pass, curr=2 prev=1
            pulse_start(2'd2, 2'd1);
            run_until_done(10000, 1, 1, 1);
            chk("u0.bp_first_addr_a", 128'(first_a[0]), 128'(128));
            chk("u1.bp_first_addr_b", 128'(first_b[1]), 128'(64));

            // reset at beat 300, then a fresh pass curr=0 prev=2
            pulse_start(2'd1, 2'd0);
            n = 0;
            while (bt_idx[0] < 300 && n < 3000) begin tick(1); n++; end
            chk("u0.reached_beat_300", 128'(bt_idx[0] >= 300), 128'(1));
            d0 = done_cnt[0]; d1 = done_cnt[1];
            rstn = 1'b0;
            repeat (2) tick(0);
            rstn = 1'b1;
            repeat (10) tick(0);
            chk("u0.no_done_after_abort", 128'(done_cnt[0]), 128'(d0));
            chk("u1.no_done_after_abort", 128'(done_cnt[1]), 128'(d1));
            pulse_start(2'd0, 2'd2);
            run_until_done(3000, 0, d0, d1);
            for (int g = 0; g < 2; g++) begin
               chk($sformatf("u%0d.restart_addr_a", g), 128'(first_a[g]), 128'(0));
               chk($sformatf("u%0d.restart_addr_b", g), 128'(first_b[g]), 128'(128));
               chk($sformatf("u%0d.restart_tag", g), 128'(first_tag[g]), 128'(0));
               chk($sformatf("u%0d.restart_prev", g), first_prev[g], 128'h800);
            end
            stim_done = 1'b1;
         end
      join
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/gcbp_bram_reader.md
Name: gcbp_bram_reader

Overview:
- Read-side counterpart to the GCBP writer.
- After each frame boundary, streams every stored sub-image line of the current and previous frames out of the 16-BRAM GCBP array, in lockstep.
- Feeds the downstream block-matching (motion estimation) engine over a valid/ready stream.
- Latches the frame-location map once at start; tolerates arbitrary backpressure without losing BRAM read data.

Parameters:
C_SUBIMAGE_HEIGHT, 64, lines per sub-image (power of 2)
C_NUM_SUBIMAGES, 16, sub-images per frame (4 rows x 4 cols), one per BRAM
C_LINE_BITS, 128, bits per GCBP sub-image line (one BRAM word)
C_ADDR_BITS, 9, BRAM address width
C_RD_LATENCY, 1, BRAM read latency in cycles (1 or 2)

Ports:
i_clk  in  1  clock
i_resetn  in  1  reset
i_start  in  1  pulse: begin a frame read pass
i_curr_frame_loc  in  2  buffer slot holding the current frame
i_prev_frame_loc  in  2  buffer slot holding the previous frame
o_bram_array_read_sel  out  4  BRAM index = sub-image index
o_bram_array_read_addr_a  out  C_ADDR_BITS  port-A address (current frame)
o_bram_array_read_addr_b  out  C_ADDR_BITS  port-B address (previous frame)
o_bram_array_read_en  out  1  read strobe, both ports
i_bram_array_read_data_a  in  C_LINE_BITS  port-A data
i_bram_array_read_data_b  in  C_LINE_BITS  port-B data
o_curr_line  out  C_LINE_BITS  current-frame line
o_prev_line  out  C_LINE_BITS  previous-frame line
o_line_valid  out  1  output beat valid
i_line_ready  in  1  downstream accepts beat
o_subimage_idx  out  4  sub-image index of beat
o_line_idx  out  6  line index of beat within sub-image
o_subimage_last  out  1  beat is line 63 of its sub-image
o_busy  out  1  pass in progress
o_done  out  1  one-cycle pulse: pass finished
o_err  out  1  one-cycle pulse: start rejected

Behaviour:
- Reset is i_resetn, synchronous, active-low; clock is i_clk.
- During reset, all outputs are 0, the FSM is in S_IDLE and the skid FIFO is empty.
- Address format: addr = {0, loc[1:0], line[5:0]}, zero-extended to C_ADDR_BITS.
  - Slot N occupies addresses N*64 .. N*64+63.
  - Port A uses the latched curr loc; port B uses the latched prev loc.
- FSM states:
  - S_IDLE: on i_start, check the locs.
    - If curr loc = 3, prev loc = 3, or curr = prev: pulse o_err for one cycle and stay in S_IDLE.
    - Otherwise: latch both locs, clear the counters, go to S_READ.
  - S_READ: issue reads in order sub 0 line 0 .. sub 15 line 63 (1024 reads).
    - Line counter increments per issued read; it wraps 63 -> 0 and increments the sub-image counter.
    - After the read for sub 15 line 63 is issued, go to S_DRAIN.
  - S_DRAIN: wait until the in-flight count is 0 and the skid FIFO is empty; then go to S_DONE.
  - S_DONE: pulse o_done for one cycle; return to S_IDLE.
- o_busy = 1 in S_READ, S_DRAIN and S_DONE.
- i_start while o_busy = 1 is ignored: no o_err, and the latched locs are unchanged.
- Read issue rule (credit based):
  - o_bram_array_read_en = 1 only when in_flight + fifo_count < C_RD_LATENCY + 1.
  - The FIFO depth is C_RD_LATENCY + 1, so the FIFO never overflows.
- Read data enters the FIFO exactly C_RD_LATENCY cycles after read_en. The capture pipeline is a shift register of valid bits and the {sub, line} tags.
- Output handshake:
  - A beat transfers when o_line_valid & i_line_ready.
  - While o_line_valid = 1 and i_line_ready = 0, all beat fields stay stable.
  - o_line_valid never drops without a transfer.
  - Beats leave in issue order.
- Throughput: with i_line_ready held at 1, one beat per cycle.
  - First beat appears C_RD_LATENCY + 1 cycles after i_start.
  - o_done occurs 2 cycles after the last beat transfers.
- A reset asserted mid-pass aborts the pass: the FIFO and counters clear and no o_done is generated.
- i_start arriving on the same cycle as o_done is ignored, because the FSM is still busy.

Decomposition:
- Shared package gcbp_pkg, holding:
  - C_SUBIMAGE_HEIGHT, C_NUM_SUBIMAGES, C_LINE_BITS, C_ADDR_BITS
  - the frame-loc encoding (slots 0..2, 3 invalid)
  - the address-format helper (loc, line -> addr)
- The writer and this reader both use gcbp_pkg.
- One sub-module: gcbp_skid_fifo.
  - Parameterised depth; 2*C_LINE_BITS+10 bits wide (both lines plus the {sub, line} tags).
  - Provides push/pop/count/valid.

Test Plan:
- Locs curr=1, prev=0; i_line_ready=1; BRAM model holds word = {slot, bram, line} -> 1024 beats in order, first beat curr line = {1,0,0} and prev line = {0,0,0}; addr_a starts at 64, addr_b at 0; o_done 2 cycles after the beat with sub=15, line=63 transfers.
- i_line_ready toggled by a random 30% duty pattern -> no beat lost or duplicated, fields stable while stalled, read_en never asserted with in_flight + count = C_RD_LATENCY + 1.
- i_start with curr=2, prev=2, and again with curr=3 -> o_err pulses once each, o_busy stays 0, no reads.
- i_start pulsed mid-pass with different locs -> ignored; addresses keep the original locs.
- i_resetn low at beat 300, then a fresh start with curr=0, prev=2 -> no o_done from the aborted pass; new pass restarts at sub 0 line 0 and addr_b = 128.
- Repeat the first and second scenarios with C_RD_LATENCY=2 -> first beat 3 cycles after start; ordering and flow control identical.
